sb_rdi_tx_fifo: RTL and testbench
=================================

Name: sb_rdi_tx_fifo

Overview:
- Sideband RDI TX message buffer between the adapter's lp_cfg interface and the sideband serializer.
- Stores each 32-bit lp_cfg chunk and presents the head word to the serializer.
- When the serializer reports completion, pops the head and emits a one-cycle read strobe.
- During that strobe, also provides the head's srcid field and an all-zeros flag, which the credit loop controller uses to return pl_cfg_crd.

Parameters:
- DATA_WIDTH, 32, width of one lp_cfg chunk / FIFO word.
- DEPTH, 8, number of FIFO entries; power of two, >= 2.
- SRCID_MSB, 30, upper bit of the srcid field inside a word.
- SRCID_LSB, 29, lower bit of the srcid field inside a word.

Ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_lp_cfg  in  DATA_WIDTH  chunk from the adapter.
- i_lp_cfg_vld  in  1  push strobe; one chunk per high cycle.
- i_ser_done  in  1  serializer done level; high after it finishes shifting the current head.
- o_fifo_data  out  DATA_WIDTH  head word, driven to the serializer.
- o_ser_valid  out  1  FIFO non-empty; head is valid.
- o_ser_done_sampled  out  1  one-cycle pop strobe.
- o_srcid  out  2  head[SRCID_MSB:SRCID_LSB].
- o_fifo_data_is_zeros  out  1  head word equals 0.
- o_fifo_full  out  1  count == DEPTH.
- o_fifo_empty  out  1  count == 0.
- o_overflow  out  1  sticky: a push was attempted while full.

Behaviour:
- Reset (i_rst_n low at a rising edge) clears rd_ptr, wr_ptr, count, the done-sample register, o_ser_done_sampled and o_overflow. Reset values:
  - o_fifo_empty = 1, o_fifo_full = 0, o_ser_valid = 0.
  - o_fifo_data = 0, o_srcid = 0, o_fifo_data_is_zeros = 1.
  - Memory contents are not reset.
  - Reset asserted mid-transfer discards all stored words; nothing is popped and no strobe is issued.
- Push:
  - At an edge where i_lp_cfg_vld = 1 and the FIFO is not full, write mem[wr_ptr] and increment wr_ptr modulo DEPTH.
  - The word is visible at the head one cycle later when the FIFO was empty (one-cycle latency).
- Push while full: the word is dropped, pointers and count are unchanged, and o_overflow is set until reset. The credit loop guarantees this never happens, so it is an error indicator only.
- Done sampling:
  - done_q <= i_ser_done every cycle.
  - o_ser_done_sampled is registered: it goes high for exactly one cycle, on the cycle after i_ser_done = 1 and done_q = 0 was seen, and only if the FIFO was non-empty at that edge.
  - If i_ser_done is held high, no further strobes occur until it drops and rises again.
- Pop: occurs at the same edge where o_ser_done_sampled = 1 and increments rd_ptr modulo DEPTH. Consequently o_srcid and o_fifo_data_is_zeros show the popped word's values throughout the strobe cycle.
- Head outputs are combinational from mem[rd_ptr]:
  - o_srcid = head[30:29].
  - o_fifo_data_is_zeros = (head == 0).
  - When empty, o_fifo_data is forced to 0, so o_srcid = 0 and is_zeros = 1.
- Count rules:
  - push only: count +1.
  - pop only: count -1.
  - push and pop in the same cycle: count unchanged; allowed when full (the pop frees the slot first, so no overflow) and when count = 1.
  - A pop on empty cannot occur because the strobe is gated.
- Pointers use log2(DEPTH) bits with natural wrap. count uses log2(DEPTH)+1 bits.

Decomposition:
- Package sb_rdi_pkg:
  - SB_DATA_WIDTH = 32.
  - SRCID field bounds 30/29.
  - srcid encodings: SRCID_STACK = 2'b00, SRCID_ADAPTER = 2'b01, SRCID_PHY = 2'b10.
  - Shared by this block, the credit loop logic and the RDI RX path.
- One sub-module, sb_rising_edge_detector (registered one-cycle pulse, sync active-low reset). It generates o_ser_done_sampled and is reused on the RX side for the pl_cfg_vld rising-edge pulse.

Test Plan:
- Reset then idle → o_fifo_empty = 1, o_ser_valid = 0, o_fifo_data = 0, o_fifo_data_is_zeros = 1, o_ser_done_sampled = 0.
- Push 0x4000_1234, then pulse i_ser_done for 2 cycles → o_fifo_data = 0x4000_1234 one cycle after the push. o_ser_done_sampled is a single 1-cycle pulse with o_srcid = 2'b10 and is_zeros = 0. The FIFO is empty the cycle after.
- Push 0x0000_0000, then done edge → strobe with o_fifo_data_is_zeros = 1 and o_srcid = 0.
- Fill 8 words (0x1..0x8), then push 0x9 → o_fifo_full = 1, o_overflow = 1, 0x9 lost. Eight done edges pop 0x1..0x8 in order across the pointer wrap.
- With 8 stored, push and done edge in the same cycle → count stays 8, o_overflow stays 0, and the new word is read out last.
- Push 3 words, assert i_rst_n = 0 for one cycle while i_ser_done is rising → no strobe, empty = 1, o_overflow = 0. The next push appears at the head correctly.

Source files
------------

// File: rtl/sb_rdi_pkg.sv
// rtl/sb_rdi_pkg.sv - shared sideband RDI word layout and srcid encodings
package sb_rdi_pkg;

   localparam int SB_DATA_WIDTH = 32;
   localparam int SB_SRCID_MSB  = 30;
   localparam int SB_SRCID_LSB  = 29;
   localparam int SB_SRCID_W    = SB_SRCID_MSB - SB_SRCID_LSB + 1;

   // Originator of a sideband message, carried in head[30:29].
   typedef enum logic [SB_SRCID_W-1:0] {
      SRCID_STACK   = 2'b00,
      SRCID_ADAPTER = 2'b01,
      SRCID_PHY     = 2'b10
   } sb_srcid_e;

endpackage

// File: rtl/sb_rising_edge_detector.sv
// rtl/sb_rising_edge_detector.sv - registered one-cycle pulse on a gated rising edge
module sb_rising_edge_detector (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_level,
   input  logic i_gate,
   output logic o_pulse
);

   logic level_q;
   logic pulse_q;
   logic pulse_d;

   // A pulse is only issued when the qualifying gate is true at the detecting edge.
   assign pulse_d = i_level & ~level_q & i_gate;

   // Track the previous level and register the pulse so it lasts exactly one cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         level_q <= i_level;
         pulse_q <= pulse_d;
      end
   end

   assign o_pulse = pulse_q;

endmodule

// File: rtl/sb_rdi_tx_fifo.sv
// rtl/sb_rdi_tx_fifo.sv - sideband RDI TX message buffer feeding the serializer
module sb_rdi_tx_fifo
   import sb_rdi_pkg::*;
#(
   parameter int DATA_WIDTH = SB_DATA_WIDTH,
   parameter int DEPTH      = 8,
   parameter int SRCID_MSB  = SB_SRCID_MSB,
   parameter int SRCID_LSB  = SB_SRCID_LSB
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_lp_cfg,
   input  logic                  i_lp_cfg_vld,
   input  logic                  i_ser_done,
   output logic [DATA_WIDTH-1:0] o_fifo_data,
   output logic                  o_ser_valid,
   output logic                  o_ser_done_sampled,
   output logic [1:0]            o_srcid,
   output logic                  o_fifo_data_is_zeros,
   output logic                  o_fifo_full,
   output logic                  o_fifo_empty,
   output logic                  o_overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  full, empty;
   logic                  push, pop;
   logic                  done_strobe;
   logic [DATA_WIDTH-1:0] head;

   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);

   // The strobe is gated on non-empty, so it is itself the pop; a simultaneous pop frees a slot when full.
   assign pop  = done_strobe;
   assign push = i_lp_cfg_vld & (~full | pop);

   sb_rising_edge_detector u_done_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_level (i_ser_done),
      .i_gate  (~empty),
      .o_pulse (done_strobe)
   );

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
      if (i_lp_cfg_vld && !push) ovf_d = 1'b1;
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array; contents are left as-is through reset since the pointers define validity.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && push) mem_q[wr_ptr_q] <= i_lp_cfg;
   end

   // Forcing the head to zero when empty makes srcid 0 and the zero flag 1 with no stale data.
   assign head = empty ? '0 : mem_q[rd_ptr_q];

   assign o_fifo_data          = head;
   assign o_ser_valid          = ~empty;
   assign o_ser_done_sampled   = done_strobe;
   assign o_srcid              = head[SRCID_MSB:SRCID_LSB];
   assign o_fifo_data_is_zeros = (head == '0);
   assign o_fifo_full          = full;
   assign o_fifo_empty         = empty;
   assign o_overflow           = ovf_q;

endmodule

// File: tb/tb_sb_rdi_tx_fifo.sv
// tb/tb_sb_rdi_tx_fifo.sv - randomized and directed bench for sb_rdi_tx_fifo
module tb_sb_rdi_tx_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] cfg;
   logic          vld;
   logic          done;
   logic [DW-1:0] fifo_data;
   logic          ser_valid, strobe, is_zeros, full, empty, ovf;
   logic [1:0]    srcid;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: a queue of stored words plus the done history and pending strobe.
   logic [DW-1:0] mq[$];
   logic          m_prev_done = 1'b0;
   logic          m_strobe    = 1'b0;
   logic          m_ovf       = 1'b0;

   always #5 clk = ~clk;

   sb_rdi_tx_fifo dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_lp_cfg             (cfg),
      .i_lp_cfg_vld         (vld),
      .i_ser_done           (done),
      .o_fifo_data          (fifo_data),
      .o_ser_valid          (ser_valid),
      .o_ser_done_sampled   (strobe),
      .o_srcid              (srcid),
      .o_fifo_data_is_zeros (is_zeros),
      .o_fifo_full          (full),
      .o_fifo_empty         (empty),
      .o_overflow           (ovf)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one rising edge to the model using the currently driven inputs.
   task automatic model_edge();
      logic pop_now;
      logic nxt;
      if (!rst_n) begin
         mq.delete();
         m_prev_done = 1'b0;
         m_strobe    = 1'b0;
         m_ovf       = 1'b0;
      end else begin
         pop_now = m_strobe;
         nxt     = done && !m_prev_done && (mq.size() != 0);
         if (pop_now) void'(mq.pop_front());
         if (vld) begin
            if (mq.size() < DEPTH) mq.push_back(cfg);
            else m_ovf = 1'b1;
         end
         m_prev_done = done;
         m_strobe    = nxt;
      end
   endtask

   task automatic check_all();
      logic [DW-1:0] h;
      h = (mq.size() != 0) ? mq[0] : '0;
      check("data",    fifo_data, h);
      check("srcid",   {30'd0, srcid}, {30'd0, h[30:29]});
      check("zeros",   {31'd0, is_zeros}, {31'd0, (h == '0)});
      check("empty",   {31'd0, empty}, {31'd0, (mq.size() == 0)});
      check("valid",   {31'd0, ser_valid}, {31'd0, (mq.size() != 0)});
      check("full",    {31'd0, full}, {31'd0, (mq.size() == DEPTH)});
      check("strobe",  {31'd0, strobe}, {31'd0, m_strobe});
      check("ovf",     {31'd0, ovf}, {31'd0, m_ovf});
   endtask

   task automatic cyc(input logic r, input logic v, input logic d, input logic [DW-1:0] w);
      rst_n = r;
      vld   = v;
      done  = d;
      cfg   = w;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      rst_n = 1'b0;
      vld   = 1'b0;
      done  = 1'b0;
      cfg   = '0;

      // Reset then idle.
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      check("rst_empty",  {31'd0, empty}, 32'd1);
      check("rst_valid",  {31'd0, ser_valid}, 32'd0);
      check("rst_data",   fifo_data, 32'd0);
      check("rst_zeros",  {31'd0, is_zeros}, 32'd1);
      check("rst_strobe", {31'd0, strobe}, 32'd0);

      // Single word with PHY srcid, done held two cycles.
      cyc(1, 1, 0, 32'h4000_1234);
      check("head_latency", fifo_data, 32'h4000_1234);
      cyc(1, 0, 1, 0);
      check("strobe_hi",    {31'd0, strobe}, 32'd1);
      check("strobe_srcid", {30'd0, srcid}, 32'd2);
      check("strobe_zeros", {31'd0, is_zeros}, 32'd0);
      cyc(1, 0, 1, 0);
      check("strobe_once",  {31'd0, strobe}, 32'd0);
      check("empty_after",  {31'd0, empty}, 32'd1);
      cyc(1, 0, 0, 0);

      // All-zeros word.
      cyc(1, 1, 0, 32'h0);
      cyc(1, 0, 1, 0);
      check("zw_strobe", {31'd0, strobe}, 32'd1);
      check("zw_zeros",  {31'd0, is_zeros}, 32'd1);
      check("zw_srcid",  {30'd0, srcid}, 32'd0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);

      // Fill across the pointer wrap, overflow on the ninth word, drain in order.
      for (int i = 1; i <= 8; i++) cyc(1, 1, 0, DW'(i));
      cyc(1, 1, 0, 32'h9);
      check("fill_full", {31'd0, full}, 32'd1);
      check("fill_ovf",  {31'd0, ovf}, 32'd1);
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 0, 1, 0);
         check("drain_word", fifo_data, DW'(i));
         cyc(1, 0, 0, 0);
      end
      check("drain_empty", {31'd0, empty}, 32'd1);

      // Push and pop together while full.
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(1, 1, 0, 32'h100 + DW'(i));
      cyc(1, 0, 1, 0);
      cyc(1, 1, 1, 32'hA5A5_0001);
      check("pp_full", {31'd0, full}, 32'd1);
      check("pp_ovf",  {31'd0, ovf}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, 0, 0);
         cyc(1, 0, 1, 0);
      end
      check("pp_last", fifo_data, 32'hA5A5_0001);
      cyc(1, 0, 0, 0);
      check("pp_empty", {31'd0, empty}, 32'd1);

      // Reset during a rising done with words stored.
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h2000_0000 + DW'(i));
      cyc(0, 0, 1, 0);
      check("mr_strobe", {31'd0, strobe}, 32'd0);
      check("mr_empty",  {31'd0, empty}, 32'd1);
      check("mr_ovf",    {31'd0, ovf}, 32'd0);
      cyc(1, 0, 1, 0);
      check("mr_nostrobe", {31'd0, strobe}, 32'd0);
      cyc(1, 1, 0, 32'h0000_0077);
      check("mr_head", fifo_data, 32'h0000_0077);
      cyc(1, 0, 0, 0);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         logic          r, v, d;
         logic [DW-1:0] w;
         r = ($urandom_range(0, 199) != 0);
         v = ($urandom_range(0, 99) < 55);
         d = ($urandom_range(0, 99) < 30) ? ~done : done;
         case ($urandom_range(0, 3))
            0:       w = '0;
            default: w = $urandom;
         endcase
         cyc(r, v, d, w);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
